hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core. It drives the stall and flush controls of PC, IF/ID and ID/EX, including the flush_IDEX input of the ID/EX register.
- Detects load-use hazards, taken branches resolved in EX, and jumps resolved in ID.
- Holds the front end while a multi-cycle mul/div op runs in EX.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_ctrl_sat_counter.sv | 19 +
 rtl/hazard_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// default mul/div latency and the hardwired-zero register number.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam int         MD_LAT_DEF = 32;
  localparam logic [4:0] REG_ZERO   = 5'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// W-bit incrementer that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage core: load-use, taken branch,
// jump in ID, and a front-end hold while a multi-cycle mul/div occupies EX.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead_EX,
  input  logic [4:0]        rt_EX,
  input  logic [4:0]        rs_ID,
  input  logic [4:0]        rt_ID,
  input  logic              BranchTaken_EX,
  input  logic              Jump_ID,
  input  logic              MulDiv_ID,
  output logic              stall_PC,
  output logic              stall_IFID,
  output logic              flush_IFID,
  output logic              flush_IDEX,
  output logic              md_busy,
  output logic              md_done,
  output logic [PERF_W-1:0] stall_cycles
);

  // cnt holds the number of busy cycles still to come after the current one,
  // so the window after the accept cycle is MD_LAT-1 cycles long.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load_use;
  logic             md_accept;

  assign load_use  = MemRead_EX && (rt_EX != REG_ZERO) &&
                     ((rt_EX == rs_ID) || (rt_EX == rt_ID));
  assign md_accept = (state == RUN) && MulDiv_ID && !BranchTaken_EX && !load_use;

  always_comb begin
    stall_PC   = 1'b0;
    stall_IFID = 1'b0;
    flush_IFID = 1'b0;
    flush_IDEX = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (BranchTaken_EX) begin
            flush_IFID = 1'b1;
            flush_IDEX = 1'b1;
          end else if (load_use) begin
            stall_PC   = 1'b1;
            stall_IFID = 1'b1;
            flush_IDEX = 1'b1;
          end else if (Jump_ID) begin
            flush_IFID = 1'b1;
          end
        end
        MD_BUSY: begin
          // ID is frozen; a branch here is a protocol error but still flushed.
          stall_PC   = 1'b1;
          stall_IFID = 1'b1;
          flush_IDEX = 1'b1;
          flush_IFID = BranchTaken_EX;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      cnt     <= '0;
      md_busy <= 1'b0;
      md_done <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (md_accept) begin
            state   <= MD_BUSY;
            cnt     <= CNT_LOAD;
            md_busy <= 1'b1;
            md_done <= (CNT_LOAD == '0);
          end
        end
        MD_BUSY: begin
          if (cnt == '0) begin
            state   <= RUN;
            md_busy <= 1'b0;
            md_done <= 1'b0;
          end else begin
            cnt     <= cnt - CNT_W'(1);
            md_done <= (cnt == CNT_W'(1));
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_PC),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MD_LAT=4, PERF_W=4): decode table in RUN,
// then mul/div window, blocked accept, reset mid-busy and counter saturation.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       MemRead_EX, BranchTaken_EX, Jump_ID, MulDiv_ID;
  logic [4:0] rt_EX, rs_ID, rt_ID;
  logic       stall_PC, stall_IFID, flush_IFID, flush_IDEX, md_busy, md_done;
  logic [3:0] stall_cycles;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  hazard_ctrl #(.MD_LAT(4), .CNT_W(6), .PERF_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .MemRead_EX     (MemRead_EX),
    .rt_EX          (rt_EX),
    .rs_ID          (rs_ID),
    .rt_ID          (rt_ID),
    .BranchTaken_EX (BranchTaken_EX),
    .Jump_ID        (Jump_ID),
    .MulDiv_ID      (MulDiv_ID),
    .stall_PC       (stall_PC),
    .stall_IFID     (stall_IFID),
    .flush_IFID     (flush_IFID),
    .flush_IDEX     (flush_IDEX),
    .md_busy        (md_busy),
    .md_done        (md_done),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mr;
    logic [4:0] rt_ex;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       jmp;
    logic       md;
    logic [3:0] exp_ctl; // {stall_PC, stall_IFID, flush_IFID, flush_IDEX}
  } vec_t;

  vec_t vecs[11];

  function automatic logic [3:0] ctl();
    return {stall_PC, stall_IFID, flush_IFID, flush_IDEX};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] rte, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic jmp, input logic md);
    MemRead_EX = mr; rt_EX = rte; rs_ID = rs; rt_ID = rt;
    BranchTaken_EX = br; Jump_ID = jmp; MulDiv_ID = md;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            mr  rt_ex rs    rt    br    jmp   md    ctl
    vecs[0]  = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1101};
    vecs[1]  = '{1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 4'b1101};
    vecs[2]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[3]  = '{1'b0, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[4]  = '{1'b1, 5'd8, 5'd7, 5'd6, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[5]  = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 4'b0011};
    vecs[6]  = '{1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 4'b0010};
    vecs[7]  = '{1'b1, 5'd4, 5'd1, 5'd4, 1'b0, 1'b1, 1'b0, 4'b1101};
    vecs[8]  = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 4'b1101};
    vecs[9]  = '{1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 4'b0011};
    vecs[10] = '{1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 4'b0011};

    // Reset state
    idle();
    reset = 1'b1;
    drive(1'b1, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0);
    #12;
    chk("reset_ctl", 32'(ctl()), 32'h0);
    chk("reset_cnt", 32'(stall_cycles), 32'h0);
    chk("reset_busy", 32'({md_busy, md_done}), 32'h0);
    idle();
    @(negedge clk);
    reset = 1'b0;
    step();

    // Decode table in RUN
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].mr, vecs[i].rt_ex, vecs[i].rs, vecs[i].rt,
            vecs[i].br, vecs[i].jmp, vecs[i].md);
      #2;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vecs[i].exp_ctl));
      step();
      if (vecs[i].exp_ctl[3]) exp_cnt++;
      chk($sformatf("vec%0d_cnt", i), 32'(stall_cycles), 32'(exp_cnt));
      chk($sformatf("vec%0d_busy", i), 32'(md_busy), 32'h0);
      $display("vec %0d ctl=%b stall_cycles=%0d", i, ctl(), stall_cycles);
      idle();
    end

    // Mul/div accept: accept cycle quiet, then 3 busy cycles, done on the third
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1);
    #2;
    chk("md_accept_ctl", 32'(ctl()), 32'h0);
    step();
    idle();
    for (int c = 1; c <= 3; c++) begin
      if (c == 1) drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0);
      if (c == 2) drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1);
      #2;
      chk($sformatf("md_busy%0d_ctl", c), 32'(ctl()), 32'b1101);
      chk($sformatf("md_busy%0d_flags", c), 32'({md_busy, md_done}),
          32'({1'b1, (c == 3)}));
      $display("md cycle %0d ctl=%b busy=%b done=%b", c, ctl(), md_busy, md_done);
      step();
      exp_cnt++;
      idle();
    end
    #2;
    chk("md_exit_flags", 32'({md_busy, md_done}), 32'h0);
    chk("md_exit_ctl", 32'(ctl()), 32'h0);
    chk("md_exit_cnt", 32'(stall_cycles), 32'(exp_cnt));
    step();

    // Mul/div blocked by load-use, accepted the next cycle
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
    #2;
    chk("blk_ctl", 32'(ctl()), 32'b1101);
    step();
    exp_cnt++;
    chk("blk_busy", 32'(md_busy), 32'h0);
    drive(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
    #2;
    chk("blk_retry_ctl", 32'(ctl()), 32'h0);
    step();
    idle();
    chk("blk_retry_busy", 32'(md_busy), 32'h1);
    $display("blocked mul/div accepted, stall_cycles=%0d", stall_cycles);

    // Reset asynchronously two cycles into the busy window
    step();
    #2;
    chk("mid_busy_pre", 32'({md_busy, stall_PC}), 32'b11);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'({md_busy, md_done, stall_PC}), 32'h0);
    chk("mid_rst_cnt", 32'(stall_cycles), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step();
    #2;
    chk("post_rst_run", 32'({md_busy, ctl()}), 32'h0);
    $display("reset mid-busy, stall_cycles=%0d", stall_cycles);

    // Saturation: hold load-use well past 15 stall cycles
    exp_cnt = 0;
    drive(1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (exp_cnt < 15) exp_cnt++;
      chk($sformatf("sat%0d", i), 32'(stall_cycles), 32'(exp_cnt));
    end
    $display("saturation stall_cycles=%0d", stall_cycles);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
